// File: rtl/pll_lock_detector.sv
// pll_lock_detector
//   Frequency lock monitor for the TX PLL. Counts CLK cycles between
//   synchronised rising edges of Ref_Clk and compares each window with
//   MULT +/- TOL. Locked sets after LOCK_CNT consecutive good windows and
//   clears after UNLOCK_CNT consecutive bad windows. Ref_Lost flags a
//   reference that has been silent for TIMEOUT CLK cycles.
//
// Ports
//   CLK        in   multiplied clock, all logic on its rising edge
//   RST_n      in   asynchronous active-low reset
//   Ref_Clk    in   reference clock, asynchronous, sampled as data
//   Enable     in   1 = monitor runs, 0 = synchronous clear to IDLE
//   Meas_Count out  last measured CLK cycles per reference period
//   Meas_Valid out  one-cycle pulse when Meas_Count updates
//   Locked     out  frequency lock indication
//   Clk_Slow   out  last window below MULT-TOL
//   Clk_Fast   out  last window above MULT+TOL
//   Ref_Lost   out  no reference edge seen for TIMEOUT cycles
module pll_lock_detector #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MULT        = 50,
  parameter int unsigned TOL         = 2,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned UNLOCK_CNT  = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 4 * MULT
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             Ref_Clk,
  input  logic             Enable,
  output logic [CNT_W-1:0] Meas_Count,
  output logic             Meas_Valid,
  output logic             Locked,
  output logic             Clk_Slow,
  output logic             Clk_Fast,
  output logic             Ref_Lost
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (!((MULT + TOL < TIMEOUT) && (64'(TIMEOUT) <= CNT_MAX))) begin : g_bad_timeout
    $error("pll_lock_detector: TIMEOUT must satisfy MULT+TOL < TIMEOUT <= 2**CNT_W-1");
  end
  if ((LOCK_CNT < 1) || (UNLOCK_CNT < 1) || (SYNC_STAGES < 2)) begin : g_bad_counts
    $error("pll_lock_detector: LOCK_CNT>=1, UNLOCK_CNT>=1 and SYNC_STAGES>=2 required");
  end

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned BAD_W  = $clog2(UNLOCK_CNT + 1);

  localparam logic signed [CNT_W:0] MULT_S = (CNT_W+1)'(MULT);
  localparam logic signed [CNT_W:0] TOL_S  = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS,
    LOCK
  } state_t;

  state_t                   state;
  logic [SYNC_STAGES-1:0]   sync;
  logic                     sync_d;
  logic                     ref_rise;
  logic [CNT_W-1:0]         cnt;
  logic [GOOD_W-1:0]        good_cnt;
  logic [BAD_W-1:0]         bad_cnt;

  logic [CNT_W:0]           meas_ext;
  logic signed [CNT_W:0]    diff;
  logic                     is_slow;
  logic                     is_fast;
  logic                     in_win;
  logic                     timeout_hit;

  // Synchroniser runs regardless of Enable so a reference already high
  // while disabled does not look like a fresh edge once enabled.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync   <= '0;
      sync_d <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], Ref_Clk};
      sync_d <= sync[SYNC_STAGES-1];
    end
  end

  assign ref_rise = sync[SYNC_STAGES-1] & ~sync_d;

  // Window length is cnt+1; one extra bit keeps the signed compare exact.
  always_comb begin
    meas_ext    = {1'b0, cnt} + (CNT_W+1)'(1);
    diff        = $signed(meas_ext) - MULT_S;
    is_slow     = (diff < -TOL_S);
    is_fast     = (diff > TOL_S);
    in_win      = !is_slow && !is_fast;
    timeout_hit = (cnt >= CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      cnt        <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      Meas_Count <= '0;
      Meas_Valid <= 1'b0;
      Locked     <= 1'b0;
      Clk_Slow   <= 1'b0;
      Clk_Fast   <= 1'b0;
      Ref_Lost   <= 1'b0;
    end else if (!Enable) begin
      state      <= IDLE;
      cnt        <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      Meas_Count <= '0;
      Meas_Valid <= 1'b0;
      Locked     <= 1'b0;
      Clk_Slow   <= 1'b0;
      Clk_Fast   <= 1'b0;
      Ref_Lost   <= 1'b0;
    end else begin
      Meas_Valid <= 1'b0;

      if (ref_rise) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          state <= ARM;
        end

        ARM: begin
          if (ref_rise) begin
            Ref_Lost <= 1'b0;
            state    <= MEAS;
          end
        end

        MEAS: begin
          if (ref_rise) begin
            Meas_Valid <= 1'b1;
            Meas_Count <= meas_ext[CNT_W-1:0];
            Clk_Slow   <= is_slow;
            Clk_Fast   <= is_fast;
            if (in_win) begin
              if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                Locked   <= 1'b1;
                good_cnt <= '0;
                state    <= LOCK;
              end else begin
                good_cnt <= good_cnt + GOOD_W'(1);
              end
            end else begin
              good_cnt <= '0;
            end
          end else if (timeout_hit) begin
            Ref_Lost <= 1'b1;
            Locked   <= 1'b0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            state    <= ARM;
          end
        end

        LOCK: begin
          if (ref_rise) begin
            Meas_Valid <= 1'b1;
            Meas_Count <= meas_ext[CNT_W-1:0];
            Clk_Slow   <= is_slow;
            Clk_Fast   <= is_fast;
            if (!in_win) begin
              if (bad_cnt == BAD_W'(UNLOCK_CNT - 1)) begin
                Locked  <= 1'b0;
                bad_cnt <= '0;
                state   <= MEAS;
              end else begin
                bad_cnt <= bad_cnt + BAD_W'(1);
              end
            end else begin
              bad_cnt <= '0;
            end
          end else if (timeout_hit) begin
            Ref_Lost <= 1'b1;
            Locked   <= 1'b0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            state    <= ARM;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_detector.sv
// tb_pll_lock_detector
//   Self-checking bench for pll_lock_detector with default parameters.
//   A cycle-level reference model built from reference-edge timestamps is
//   compared against every DUT output on each falling CLK edge; table rows
//   and hand sequences check window results, lock/unlock counts, timeout
//   timing, reset and Enable clearing.
module tb_pll_lock_detector;

  localparam int CNT_W       = 16;
  localparam int MULT        = 50;
  localparam int TOL         = 2;
  localparam int LOCK_CNT    = 4;
  localparam int UNLOCK_CNT  = 2;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 4 * MULT;

  logic             CLK = 1'b0;
  logic             RST_n;
  logic             Ref_Clk;
  logic             Enable;
  logic [CNT_W-1:0] Meas_Count;
  logic             Meas_Valid;
  logic             Locked;
  logic             Clk_Slow;
  logic             Clk_Fast;
  logic             Ref_Lost;

  pll_lock_detector #(
    .CNT_W      (CNT_W),
    .MULT       (MULT),
    .TOL        (TOL),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .Ref_Clk   (Ref_Clk),
    .Enable    (Enable),
    .Meas_Count(Meas_Count),
    .Meas_Valid(Meas_Valid),
    .Locked    (Locked),
    .Clk_Slow  (Clk_Slow),
    .Clk_Fast  (Clk_Fast),
    .Ref_Lost  (Ref_Lost)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // ---------------- reference model ----------------
  // Phases: 0 disabled, 1 waiting for first edge, 2 measuring, 3 locked.
  int   edge_n;
  int   rise_q[$];
  logic prev_ref;
  int   m_phase, m_last, m_good, m_bad, m_count;
  logic m_valid, m_locked, m_slow, m_fast, m_lost;

  always @(posedge CLK or negedge RST_n) begin : model
    int e;
    int n;
    bit rise;
    bit good;
    if (!RST_n) begin
      rise_q.delete();
      edge_n   <= 0;
      prev_ref <= 1'b0;
      m_phase  <= 0;
      m_last   <= 0;
      m_good   <= 0;
      m_bad    <= 0;
      m_count  <= 0;
      m_valid  <= 1'b0;
      m_locked <= 1'b0;
      m_slow   <= 1'b0;
      m_fast   <= 1'b0;
      m_lost   <= 1'b0;
    end else begin
      e    = edge_n + 1;
      // A 0->1 sample taken at edge k is acted upon SYNC_STAGES edges later.
      rise = (rise_q.size() != 0) && (rise_q[0] == e - SYNC_STAGES);
      if (rise) void'(rise_q.pop_front());
      if (Ref_Clk && !prev_ref) rise_q.push_back(e);
      edge_n   <= e;
      prev_ref <= Ref_Clk;
      m_valid  <= 1'b0;
      n    = e - m_last;
      good = (n >= MULT - TOL) && (n <= MULT + TOL);
      if (!Enable) begin
        m_phase  <= 0;
        m_good   <= 0;
        m_bad    <= 0;
        m_count  <= 0;
        m_locked <= 1'b0;
        m_slow   <= 1'b0;
        m_fast   <= 1'b0;
        m_lost   <= 1'b0;
      end else if (m_phase == 0) begin
        m_phase <= 1;
      end else if (m_phase == 1) begin
        if (rise) begin
          m_last  <= e;
          m_lost  <= 1'b0;
          m_phase <= 2;
        end
      end else if (rise) begin
        m_valid <= 1'b1;
        m_count <= n;
        m_slow  <= (n < MULT - TOL);
        m_fast  <= (n > MULT + TOL);
        m_last  <= e;
        if (m_phase == 2) begin
          if (!good) m_good <= 0;
          else if (m_good + 1 >= LOCK_CNT) begin
            m_good <= 0; m_locked <= 1'b1; m_phase <= 3;
          end else m_good <= m_good + 1;
        end else begin
          if (good) m_bad <= 0;
          else if (m_bad + 1 >= UNLOCK_CNT) begin
            m_bad <= 0; m_locked <= 1'b0; m_phase <= 2;
          end else m_bad <= m_bad + 1;
        end
      end else if (n >= TIMEOUT) begin
        m_lost   <= 1'b1;
        m_locked <= 1'b0;
        m_good   <= 0;
        m_bad    <= 0;
        m_phase  <= 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  typedef struct {
    int   cnt;
    logic slow;
    logic fast;
    logic locked;
    logic lost;
  } rec_t;

  rec_t rec_q[$];

  typedef struct {
    int   period;
    int   cnt;
    logic slow;
    logic fast;
    logic locked;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic step();
    @(negedge CLK);
    cyc++;
    checks++;
    if ({Meas_Count, Meas_Valid, Locked, Clk_Slow, Clk_Fast, Ref_Lost} !==
        {CNT_W'(m_count), m_valid, m_locked, m_slow, m_fast, m_lost}) begin
      failures++;
      $display("FAIL model_cycle%0d actual cnt=%0d v=%b lk=%b slow=%b fast=%b lost=%b required cnt=%0d v=%b lk=%b slow=%b fast=%b lost=%b",
               cyc, Meas_Count, Meas_Valid, Locked, Clk_Slow, Clk_Fast, Ref_Lost,
               m_count, m_valid, m_locked, m_slow, m_fast, m_lost);
    end
    if (Meas_Valid) rec_q.push_back('{int'(Meas_Count), Clk_Slow, Clk_Fast, Locked, Ref_Lost});
  endtask

  // Ref_Clk rises now, stays high for hi cycles; next rise follows p cycles later.
  task automatic ref_period(input int p, input int hi);
    Ref_Clk = 1'b1;
    repeat (hi) step();
    Ref_Clk = 1'b0;
    repeat (p - hi) step();
  endtask

  task automatic pad_recs(input int n);
    while (rec_q.size() < n) rec_q.push_back('{-1, 1'bx, 1'bx, 1'bx, 1'bx});
  endtask

  // Relock after a clear: first edge arms, lock appears with the 4th valid.
  task automatic relock_check(input string tag);
    rec_q.delete();
    repeat (5) ref_period(MULT, MULT / 2);
    chk({tag, "_valids"}, rec_q.size(), 4);
    pad_recs(4);
    chk({tag, "_locked3"}, int'(rec_q[2].locked), 0);
    chk({tag, "_locked4"}, int'(rec_q[3].locked), 1);
  endtask

  initial begin
    int k;

    tbl[0]  = '{50, 50, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{50, 50, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{52, 52, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{48, 48, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{45, 45, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{50, 50, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{45, 45, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{45, 45, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{53, 53, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{47, 47, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{52, 52, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{48, 48, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{52, 52, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{53, 53, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{48, 48, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{52, 52, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{50, 50, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{49, 49, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{48, 48, 1'b0, 1'b0, 1'b1};

    RST_n   = 1'b0;
    Enable  = 1'b0;
    Ref_Clk = 1'b0;
    repeat (3) step();
    chk("reset_outputs", int'({Meas_Count, Meas_Valid, Locked, Clk_Slow, Clk_Fast, Ref_Lost}), 0);
    RST_n = 1'b1;
    repeat (2) step();
    Enable = 1'b1;
    repeat (3) step();

    // Table: consecutive windows after the arming edge.
    rec_q.delete();
    for (int i = 0; i < 19; i++) ref_period(tbl[i].period, tbl[i].period / 2);

    // Closing edge of the last window, then the reference stops.
    Ref_Clk = 1'b1;
    k = 0;
    while (!Meas_Valid && k < 20) begin
      step();
      k++;
    end
    chk("closing_valid_seen", int'(Meas_Valid), 1);
    k = 0;
    while (!Ref_Lost && k < 400) begin
      step();
      k++;
      if (k == 8) Ref_Clk = 1'b0;
    end
    chk("timeout_cycles", k, TIMEOUT);
    chk("timeout_locked", int'(Locked), 0);

    chk("table_valids", rec_q.size(), 19);
    pad_recs(19);
    for (int i = 0; i < 19; i++) begin
      chk($sformatf("row%0d_cnt", i), rec_q[i].cnt, tbl[i].cnt);
      chk($sformatf("row%0d_slow", i), int'(rec_q[i].slow), int'(tbl[i].slow));
      chk($sformatf("row%0d_fast", i), int'(rec_q[i].fast), int'(tbl[i].fast));
      chk($sformatf("row%0d_locked", i), int'(rec_q[i].locked), int'(tbl[i].locked));
    end

    // Restart after loss: lock returns on the 5th edge.
    relock_check("restart");
    chk("restart_lost", int'(Ref_Lost), 0);

    // Edge exactly at the timeout boundary wins; one cycle later times out.
    rec_q.delete();
    ref_period(TIMEOUT, 100);
    ref_period(TIMEOUT + 1, 100);
    repeat (5) step();
    chk("boundary_lost_after_201", int'(Ref_Lost), 1);
    chk("boundary_locked_after_201", int'(Locked), 0);
    chk("boundary_valids", rec_q.size(), 2);
    pad_recs(2);
    chk("boundary_cnt", rec_q[1].cnt, TIMEOUT);
    chk("boundary_fast", int'(rec_q[1].fast), 1);
    chk("boundary_no_lost", int'(rec_q[1].lost), 0);
    chk("boundary_still_locked", int'(rec_q[1].locked), 1);
    ref_period(MULT, MULT / 2);
    chk("rearm_lost_clear", int'(Ref_Lost), 0);
    chk("rearm_no_valid", rec_q.size(), 2);

    // Asynchronous reset while locked.
    repeat (5) ref_period(MULT, MULT / 2);
    chk("prereset_locked", int'(Locked), 1);
    @(posedge CLK);
    #2 RST_n = 1'b0;
    #1 chk("async_reset_outputs", int'({Meas_Count, Meas_Valid, Locked, Clk_Slow, Clk_Fast, Ref_Lost}), 0);
    repeat (2) step();
    RST_n = 1'b1;
    step();
    relock_check("after_reset");

    // One-cycle Enable drop while locked.
    Enable = 1'b0;
    step();
    chk("enable_drop_outputs", int'({Meas_Count, Meas_Valid, Locked, Clk_Slow, Clk_Fast, Ref_Lost}), 0);
    Enable = 1'b1;
    step();
    relock_check("after_enable");

    // Alternating 48/52 windows all count as good.
    rec_q.delete();
    repeat (2) begin
      ref_period(48, 24);
      ref_period(52, 26);
    end
    ref_period(48, 24);
    chk("alt_locked", int'(Locked), 1);

    // Random periods, high times, long gaps and Enable drops vs the model.
    for (int i = 0; i < 40; i++) begin
      int p;
      int hi;
      p = MULT - 6 + int'($urandom_range(12));
      if ($urandom_range(9) == 0) p = TIMEOUT - 5 + int'($urandom_range(10));
      if ($urandom_range(14) == 0) begin
        Enable = 1'b0;
        repeat (1 + $urandom_range(2)) step();
        Enable = 1'b1;
      end
      hi = 1 + int'($urandom_range(p - 2));
      ref_period(p, hi);
    end
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
